ab_link: RTL and testbench



---
 rtl/ab_link.sv | 121 ++++++++++++
 tb/tb_ab_link.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ab_link.sv
// Registered, flow-controlled bidirectional link between module A and module B.
// Each direction is an independent FIFO with valid/ready handshakes, occupancy count and flush.

module ab_link_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  // Handshake flags come from the registered count only, so ready never sees rd_ready.
  assign wr_ready = (count != FULL);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush leaves stale entries in place; only rst scrubs the storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

module ab_link #(
  parameter  int A_TO_B_BITWIDTH = 8,
  parameter  int B_TO_A_BITWIDTH = 8,
  parameter  int FIFO_DEPTH      = 4,
  localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [A_TO_B_BITWIDTH-1:0] a_tx_data,
  input  logic                       a_tx_valid,
  output logic                       a_tx_ready,
  output logic [A_TO_B_BITWIDTH-1:0] b_rx_data,
  output logic                       b_rx_valid,
  input  logic                       b_rx_ready,
  input  logic [B_TO_A_BITWIDTH-1:0] b_tx_data,
  input  logic                       b_tx_valid,
  output logic                       b_tx_ready,
  output logic [B_TO_A_BITWIDTH-1:0] a_rx_data,
  output logic                       a_rx_valid,
  input  logic                       a_rx_ready,
  output logic [CW-1:0]              a_to_b_count,
  output logic [CW-1:0]              b_to_a_count
);

  ab_link_fifo #(
    .WIDTH (A_TO_B_BITWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_a_to_b (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_data  (a_tx_data),
    .wr_valid (a_tx_valid),
    .wr_ready (a_tx_ready),
    .rd_data  (b_rx_data),
    .rd_valid (b_rx_valid),
    .rd_ready (b_rx_ready),
    .count    (a_to_b_count)
  );

  ab_link_fifo #(
    .WIDTH (B_TO_A_BITWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_b_to_a (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_data  (b_tx_data),
    .wr_valid (b_tx_valid),
    .wr_ready (b_tx_ready),
    .rd_data  (a_rx_data),
    .rd_valid (a_rx_valid),
    .rd_ready (a_rx_ready),
    .count    (b_to_a_count)
  );

endmodule

// File: tb/tb_ab_link.sv
// Scoreboard bench for ab_link: each direction is modelled as a queue of accepted entries,
// and the DUT's flags, counts and head data are compared against it every cycle.

module tb_ab_link;

  localparam int AW = 8;
  localparam int BW = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW-1:0] a_tx_data;
  logic          a_tx_valid;
  logic          a_tx_ready;
  logic [AW-1:0] b_rx_data;
  logic          b_rx_valid;
  logic          b_rx_ready;
  logic [BW-1:0] b_tx_data;
  logic          b_tx_valid;
  logic          b_tx_ready;
  logic [BW-1:0] a_rx_data;
  logic          a_rx_valid;
  logic          a_rx_ready;
  logic [CW-1:0] a_to_b_count;
  logic [CW-1:0] b_to_a_count;

  logic [AW-1:0] ab_q[$];
  logic [BW-1:0] ba_q[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ab_link #(
    .A_TO_B_BITWIDTH (AW),
    .B_TO_A_BITWIDTH (BW),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .a_tx_data    (a_tx_data),
    .a_tx_valid   (a_tx_valid),
    .a_tx_ready   (a_tx_ready),
    .b_rx_data    (b_rx_data),
    .b_rx_valid   (b_rx_valid),
    .b_rx_ready   (b_rx_ready),
    .b_tx_data    (b_tx_data),
    .b_tx_valid   (b_tx_valid),
    .b_tx_ready   (b_tx_ready),
    .a_rx_data    (a_rx_data),
    .a_rx_valid   (a_rx_valid),
    .a_rx_ready   (a_rx_ready),
    .a_to_b_count (a_to_b_count),
    .b_to_a_count (b_to_a_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One clock cycle: drive inputs after negedge, compare against the queues, then advance the model.
  task automatic applyStimulus(input logic av, input logic [AW-1:0] ad, input logic brdy,
                               input logic bv, input logic [BW-1:0] bd, input logic ardy,
                               input logic fl, input logic rs);
    logic ab_wr, ab_rd, ba_wr, ba_rd;
    @(negedge clk);
    a_tx_valid = av;  a_tx_data = ad;  b_rx_ready = brdy;
    b_tx_valid = bv;  b_tx_data = bd;  a_rx_ready = ardy;
    flush = fl;  rst = rs;
    #1;
    checkOutput("a_tx_ready",   32'(a_tx_ready),   32'(ab_q.size() != D));
    checkOutput("b_rx_valid",   32'(b_rx_valid),   32'(ab_q.size() != 0));
    checkOutput("a_to_b_count", 32'(a_to_b_count), 32'(ab_q.size()));
    if (ab_q.size() != 0) checkOutput("b_rx_data", 32'(b_rx_data), 32'(ab_q[0]));
    checkOutput("b_tx_ready",   32'(b_tx_ready),   32'(ba_q.size() != D));
    checkOutput("a_rx_valid",   32'(a_rx_valid),   32'(ba_q.size() != 0));
    checkOutput("b_to_a_count", 32'(b_to_a_count), 32'(ba_q.size()));
    if (ba_q.size() != 0) checkOutput("a_rx_data", 32'(a_rx_data), 32'(ba_q[0]));
    ab_wr = av && (ab_q.size() != D);
    ab_rd = brdy && (ab_q.size() != 0);
    ba_wr = bv && (ba_q.size() != D);
    ba_rd = ardy && (ba_q.size() != 0);
    if (fl || rs) begin
      ab_q.delete();
      ba_q.delete();
    end else begin
      if (ab_rd) void'(ab_q.pop_front());
      if (ab_wr) ab_q.push_back(ad);
      if (ba_rd) void'(ba_q.pop_front());
      if (ba_wr) ba_q.push_back(bd);
    end
    @(posedge clk);
  endtask

  task automatic checkResetState();
    @(negedge clk);
    rst = 1'b0;  flush = 1'b0;
    a_tx_valid = 1'b0;  b_tx_valid = 1'b0;  b_rx_ready = 1'b0;  a_rx_ready = 1'b0;
    #1;
    checkOutput("rst a_tx_ready",   32'(a_tx_ready),   32'd1);
    checkOutput("rst b_tx_ready",   32'(b_tx_ready),   32'd1);
    checkOutput("rst b_rx_valid",   32'(b_rx_valid),   32'd0);
    checkOutput("rst a_rx_valid",   32'(a_rx_valid),   32'd0);
    checkOutput("rst b_rx_data",    32'(b_rx_data),    32'd0);
    checkOutput("rst a_rx_data",    32'(a_rx_data),    32'd0);
    checkOutput("rst a_to_b_count", 32'(a_to_b_count), 32'd0);
    checkOutput("rst b_to_a_count", 32'(b_to_a_count), 32'd0);
    @(posedge clk);
  endtask

  initial begin
    // Reset for two cycles with random activity on every input.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;  flush = 1'($urandom);
      a_tx_valid = 1'($urandom);  a_tx_data = AW'($urandom);  b_rx_ready = 1'($urandom);
      b_tx_valid = 1'($urandom);  b_tx_data = BW'($urandom);  a_rx_ready = 1'($urandom);
    end
    checkResetState();

    // Fill with the consumer stalled, offer a fifth word, then drain in order.
    applyStimulus(1, 8'h11, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 8'h22, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 8'h33, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 8'h44, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 8'h55, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0, '0, 0, 0, 0);

    // Continuous streaming; pointers wrap several times.
    for (int i = 0; i < 20; i++) applyStimulus(1, AW'(i), 1, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, '0, 0, 0, 0);

    // Full with simultaneous write offer and read.
    for (int i = 0; i < 4; i++) applyStimulus(1, AW'(8'hC0 + i), 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 8'h66, 1, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, 1, 0, '0, 0, 0, 0);

    // Flush with traffic queued in both directions and a write in the flush cycle.
    applyStimulus(1, 8'h01, 0, 1, 16'h1001, 0, 0, 0);
    applyStimulus(1, 8'h02, 0, 1, 16'h1002, 0, 0, 0);
    applyStimulus(1, 8'h03, 0, 0, '0,       0, 0, 0);
    applyStimulus(1, 8'h77, 0, 1, 16'h7777, 0, 1, 0);
    applyStimulus(0, '0, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 8'hA5, 0, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, '0, 0, 0, 0);

    // B to A streams while A to B holds one stalled entry.
    applyStimulus(1, 8'h5A, 0, 0, '0,       0, 0, 0);
    applyStimulus(0, '0,    0, 1, 16'h1234, 1, 0, 0);
    applyStimulus(0, '0,    0, 1, 16'hBEEF, 1, 0, 0);
    applyStimulus(0, '0,    0, 0, '0,       1, 0, 0);
    applyStimulus(0, '0,    0, 0, '0,       1, 0, 0);
    applyStimulus(0, '0,    1, 0, '0,       0, 0, 0);

    // Reset mid-transfer drops queued data and scrubs storage.
    applyStimulus(1, 8'h9C, 0, 1, 16'h4321, 0, 0, 0);
    applyStimulus(1, 8'h9D, 0, 1, 16'h4322, 0, 0, 0);
    applyStimulus(1, 8'h9E, 1, 1, 16'h4323, 1, 1, 1);
    checkResetState();
    applyStimulus(0, '0, 1, 0, '0, 1, 0, 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
